// File: rtl/simple_axi_pkg.sv
// Shared AXI response codes, FSM encodings and address decode for the simple AXI master/slave pair.
package simple_axi_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;

  // Decode error outranks an unsupported burst length.
  function automatic resp_e decode_resp(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [32:0] size, input logic [7:0] len);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    if (addr < base || off >= size) return RESP_DECERR;
    if (len != 8'd0) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction
endpackage

// File: rtl/simple_axi_ram.sv
// 64-bit synchronous RAM: byte-enabled write port, registered read port with enable.
module simple_axi_ram #(
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wstrb,
  input  logic [63:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [63:0]   o_rdata
);
  logic [63:0] r_mem [WORDS];

  // Read and write share the edge, so a colliding read sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_we)
      for (int b = 0; b < 8; b++)
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/simple_axi_slave_ram.sv
// Single-beat AXI slave in front of a 64-bit RAM; independent write and read FSMs.
module simple_axi_slave_ram
  import simple_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MEM_BYTES  = 4096,
  parameter int          RD_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast
);
  localparam int          WORDS  = MEM_BYTES / 8;
  localparam int          AW     = $clog2(WORDS);
  localparam logic [32:0] SIZE   = 33'(MEM_BYTES);
  localparam logic [3:0]  LAT_M1 = 4'(RD_LATENCY - 1);

  wstate_e       r_wstate, w_wnext;
  rstate_e       r_rstate, w_rnext;
  resp_e         r_bresp, r_rresp;
  logic          r_live;
  logic [AW-1:0] r_waddr, r_raddr, w_ram_raddr;
  logic [3:0]    r_cnt;
  logic          w_aw_hs, w_wl_hs, w_ar_hs, w_we, w_re;
  logic [63:0]   w_ram_rdata;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 3);
  endfunction

  // Keeps awready/arready low until the first edge after reset releases.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_live <= 1'b0;
    else       r_live <= 1'b1;

  assign s_axi_awready = r_live && (r_wstate == W_IDLE);
  assign s_axi_wready  = (r_wstate == W_DATA);
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_bresp   = s_axi_bvalid ? r_bresp : RESP_OKAY;
  assign s_axi_arready = r_live && (r_rstate == R_IDLE);
  assign s_axi_rvalid  = (r_rstate == R_DATA);
  assign s_axi_rlast   = s_axi_rvalid;
  assign s_axi_rresp   = s_axi_rvalid ? r_rresp : RESP_OKAY;
  assign s_axi_rdata   = (s_axi_rvalid && r_rresp == RESP_OKAY) ? w_ram_rdata : 64'd0;

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_wl_hs = s_axi_wvalid && s_axi_wready && s_axi_wlast;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;
  assign w_we    = w_wl_hs && (r_bresp == RESP_OKAY);

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_wstate <= W_IDLE;
    else       r_wstate <= w_wnext;

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
      W_DATA:  if (w_wl_hs) w_wnext = W_RESP;
      W_RESP:  if (s_axi_bready) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_bresp <= RESP_OKAY;
      r_waddr <= '0;
    end else if (w_aw_hs) begin
      r_bresp <= decode_resp(s_axi_awaddr, BASE_ADDR, SIZE, s_axi_awlen);
      r_waddr <= word_idx(s_axi_awaddr);
    end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_rstate <= R_IDLE;
    else       r_rstate <= w_rnext;

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = (RD_LATENCY == 1) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_cnt == 4'd0) w_rnext = R_DATA;
      R_DATA:  if (s_axi_rready) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_rresp <= RESP_OKAY;
      r_raddr <= '0;
      r_cnt   <= '0;
    end else if (w_ar_hs) begin
      r_rresp <= decode_resp(s_axi_araddr, BASE_ADDR, SIZE, s_axi_arlen);
      r_raddr <= word_idx(s_axi_araddr);
      r_cnt   <= LAT_M1;
    end else if (r_rstate == R_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end

  // RAM output register is loaded exactly on the edge that enters R_DATA, then holds.
  assign w_re        = (w_rnext == R_DATA) && (r_rstate != R_DATA);
  assign w_ram_raddr = (r_rstate == R_IDLE) ? word_idx(s_axi_araddr) : r_raddr;

  simple_axi_ram #(.WORDS(WORDS), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_waddr),
    .i_wstrb (s_axi_wstrb),
    .i_wdata (s_axi_wdata),
    .i_re    (w_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );
endmodule

// File: tb/tb_simple_axi_slave_ram.sv
// Directed bench for simple_axi_slave_ram: write/read, strobes, errors, backpressure, reset mid-write.
module tb_simple_axi_slave_ram;
  localparam int LAT = 2;

  logic        i_clk, i_rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic        s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic        s_axi_rvalid, s_axi_rready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;

  int n_chk = 0;
  int n_fail = 0;

  simple_axi_slave_ram #(.BASE_ADDR(32'h0), .MEM_BYTES(4096), .RD_LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                s_axi_rvalid, s_axi_rlast, s_axi_bresp, s_axi_rresp});
  endfunction

  task automatic aw_phase(input string tag, input logic [31:0] a, input logic [7:0] len);
    int n;
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(posedge i_clk); #1; n++; end
    if (n >= 50) chk({tag, "_aw_timeout"}, 64'(0), 64'(1));
    @(posedge i_clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic axi_wr(input string tag, input logic [31:0] a, input logic [7:0] len,
                        input logic [63:0] d, input logic [7:0] s, input int hold,
                        input logic [1:0] exp_resp);
    int n;
    aw_phase(tag, a, len);
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_wready && n < 50) begin @(posedge i_clk); #1; n++; end
    if (n >= 50) chk({tag, "_w_timeout"}, 64'(0), 64'(1));
    @(posedge i_clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(posedge i_clk); #1; n++; end
    if (n >= 50) chk({tag, "_b_timeout"}, 64'(0), 64'(1));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_bvalid"}, 64'(s_axi_bvalid), 64'(1));
      chk({tag, "_hold_bresp"}, 64'(s_axi_bresp), 64'(exp_resp));
      chk({tag, "_hold_awready"}, 64'(s_axi_awready), 64'(0));
      @(posedge i_clk); #1;
    end
    chk({tag, "_bresp"}, 64'(s_axi_bresp), 64'(exp_resp));
    s_axi_bready = 1'b1;
    @(posedge i_clk); #1;
    s_axi_bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 64'(s_axi_bvalid), 64'(0));
  endtask

  task automatic axi_rd(input string tag, input logic [31:0] a, input logic [7:0] len,
                        input int hold, input logic [63:0] exp_data, input logic [1:0] exp_resp);
    int n;
    int lat;
    s_axi_araddr = a; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(posedge i_clk); #1; n++; end
    if (n >= 50) chk({tag, "_ar_timeout"}, 64'(0), 64'(1));
    @(posedge i_clk); #1;
    s_axi_arvalid = 1'b0;
    lat = 0;
    while (!s_axi_rvalid && lat < 50) begin @(posedge i_clk); #1; lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_rvalid"}, 64'(s_axi_rvalid), 64'(1));
      chk({tag, "_hold_rdata"}, s_axi_rdata, exp_data);
      chk({tag, "_hold_rresp"}, 64'(s_axi_rresp), 64'(exp_resp));
      chk({tag, "_hold_arready"}, 64'(s_axi_arready), 64'(0));
      @(posedge i_clk); #1;
    end
    chk({tag, "_rdata"}, s_axi_rdata, exp_data);
    chk({tag, "_rresp"}, 64'(s_axi_rresp), 64'(exp_resp));
    chk({tag, "_rlast"}, 64'(s_axi_rlast), 64'(1));
    s_axi_rready = 1'b1;
    @(posedge i_clk); #1;
    s_axi_rready = 1'b0;
    chk({tag, "_rvalid_drop"}, 64'(s_axi_rvalid), 64'(0));
  endtask

  initial begin
    i_rst = 1'b1;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_rready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_outs", all_outs(), 64'(0));
    chk("rst_rdata", s_axi_rdata, 64'(0));
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("post_rst_ready", 64'({s_axi_awready, s_axi_arready}), 64'(2'b11));

    axi_wr("wr100", 32'h100, 8'd0, 64'h1122_3344_5566_7788, 8'hFF, 0, 2'b00);
    axi_rd("rd100", 32'h100, 8'd0, 0, 64'h1122_3344_5566_7788, 2'b00);

    axi_wr("wr108z", 32'h108, 8'd0, 64'h0, 8'hFF, 0, 2'b00);
    axi_wr("wr10a", 32'h10A, 8'd0, 64'h0000_0000_00AB_0000, 8'h04, 0, 2'b00);
    axi_rd("rd108", 32'h108, 8'd0, 0, 64'h0000_0000_00AB_0000, 2'b00);

    axi_wr("wr000", 32'h0, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 2'b00);
    axi_wr("wr2000", 32'h2000, 8'd0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 2'b11);
    axi_rd("rd000", 32'h0, 8'd0, 0, 64'h0123_4567_89AB_CDEF, 2'b00);
    axi_rd("rd2000", 32'h2000, 8'd0, 0, 64'h0, 2'b11);
    axi_rd("rdburst", 32'h100, 8'd3, 0, 64'h0, 2'b10);
    axi_wr("wrburst", 32'h100, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 2'b10);
    axi_rd("rd100b", 32'h100, 8'd0, 0, 64'h1122_3344_5566_7788, 2'b00);

    axi_wr("wrlast", 32'hFF8, 8'd0, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 0, 2'b00);
    axi_rd("rdlast", 32'hFFF, 8'd0, 0, 64'hA5A5_5A5A_0F0F_F0F0, 2'b00);
    axi_rd("rd1000", 32'h1000, 8'd0, 0, 64'h0, 2'b11);

    axi_wr("bp_wr", 32'h110, 8'd0, 64'hCAFE_F00D_1234_5678, 8'hFF, 5, 2'b00);
    axi_rd("bp_rd", 32'h110, 8'd0, 5, 64'hCAFE_F00D_1234_5678, 2'b00);

    // Reset lands in W_DATA after one non-last beat, with the last beat pending.
    aw_phase("rstw", 32'h100, 8'd0);
    chk("rstw_wready", 64'(s_axi_wready), 64'(1));
    s_axi_wdata = 64'hFFFF_FFFF_FFFF_FFFF; s_axi_wstrb = 8'hFF;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
    @(posedge i_clk); #1;
    s_axi_wlast = 1'b1;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rstw_outs0", all_outs(), 64'(0));
    chk("rstw_rdata0", s_axi_rdata, 64'(0));
    @(posedge i_clk); #1;
    chk("rstw_outs1", all_outs(), 64'(0));
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    axi_rd("rstw_rd", 32'h100, 8'd0, 0, 64'h1122_3344_5566_7788, 2'b00);
    axi_wr("rstw_wr2", 32'h100, 8'd0, 64'h8877_6655_4433_2211, 8'hFF, 0, 2'b00);
    axi_rd("rstw_rd2", 32'h100, 8'd0, 0, 64'h8877_6655_4433_2211, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
